// File: rtl/clock_set_pkg.sv
// ============================================================================
//  Module      : clock_set_pkg
//  Description : Shared state encoding, BCD limits, blink masks and BCD
//                time helpers for the clock set-mode controller.
//                Optional build macro used by clock_set_ctrl:
//                CLOCK_SET_AUTO_REPEAT_EN (hold-to-repeat increments).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_set_pkg;

    // Set-mode FSM encoding
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;
    localparam logic [1:0] ST_LOAD    = 2'd3;

    // BCD limits
    localparam int         MAX_HR   = 23;
    localparam logic [3:0] MAX_MIN1 = 4'd5;
    localparam logic [3:0] BCD_MAX  = 4'd9;

    // Display blanking masks (bit0 = seconds units ... bit5 = hours tens)
    localparam logic [5:0] BLINK_MASK_HR  = 6'b110000;
    localparam logic [5:0] BLINK_MASK_MIN = 6'b001100;

    // Editable part of the time, one BCD nibble per digit
    typedef struct packed {
        logic [3:0] hr1;
        logic [3:0] hr0;
        logic [3:0] min1;
        logic [3:0] min0;
    } hhmm_t;

    // Binary value of a two-digit BCD field
    function automatic int bcd_val(input logic [3:0] hi, input logic [3:0] lo);
        return int'(hi) * 10 + int'(lo);
    endfunction

    // Replace illegal fields of a live snapshot by zero: an out-of-range hour
    // clears both hour digits, each bad minute digit clears only itself.
    function automatic hhmm_t sanitize(input hhmm_t t);
        hhmm_t r;
        r = t;
        if ((t.hr1 > BCD_MAX) || (t.hr0 > BCD_MAX) || (bcd_val(t.hr1, t.hr0) > MAX_HR)) begin
            r.hr1 = 4'd0;
            r.hr0 = 4'd0;
        end
        if (t.min1 > MAX_MIN1) begin
            r.min1 = 4'd0;
        end
        if (t.min0 > BCD_MAX) begin
            r.min0 = 4'd0;
        end
        return r;
    endfunction

    // Hours 00 -> 23 -> 00 with BCD carry from units into tens
    function automatic hhmm_t hr_inc(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (bcd_val(t.hr1, t.hr0) >= MAX_HR) begin
            r.hr1 = 4'd0;
            r.hr0 = 4'd0;
        end else if (t.hr0 >= BCD_MAX) begin
            r.hr1 = t.hr1 + 4'd1;
            r.hr0 = 4'd0;
        end else begin
            r.hr0 = t.hr0 + 4'd1;
        end
        return r;
    endfunction

    // Minutes 00 -> 59 -> 00; no carry into the hours
    function automatic hhmm_t min_inc(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.min0 >= BCD_MAX) begin
            r.min0 = 4'd0;
            r.min1 = (t.min1 >= MAX_MIN1) ? 4'd0 : (t.min1 + 4'd1);
        end else begin
            r.min0 = t.min0 + 4'd1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_set_ctrl_btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : Two-flop synchronizer, tick-based debouncer and rising-edge
//                press pulse for one raw push-button.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int            CW         = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;

    // Count consecutive disagreeing ticks; accept the new level on the last one
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (tick_en_i) begin
            if (sync_q[1] != level_q) begin
                if (cnt_q == C_CNT_LAST) begin
                    level_d = sync_q[1];
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Synchronizer, debounce state and edge-detect delay
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b00;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_i};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    assign level_o = level_q;
    // Releases produce no event: only the rising edge of the debounced level
    assign press_o = level_q & ~level_dly_q;

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
//  Module      : clock_set_ctrl
//  Description : Set-mode controller for the HH:MM:SS counter chain. Debounces
//                the mode/inc buttons, lets the user edit hours and minutes in
//                BCD, then issues a one-cycle parallel load (seconds load as 0
//                in the chain) and drives the display blink mask.
//                Build macro CLOCK_SET_AUTO_REPEAT_EN adds hold-to-repeat on
//                the increment button; without it each press is one step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl #(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int BLINK_TICKS    = 250,
    parameter int HOLD_TICKS     = 600,
    parameter int REPEAT_TICKS   = 150
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hr1,
    input  logic [3:0] cur_hr0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    output logic       run_ena,
    output logic       load,
    output logic [3:0] ld_hr1,
    output logic [3:0] ld_hr0,
    output logic [3:0] ld_min1,
    output logic [3:0] ld_min0,
    output logic       set_active,
    output logic [5:0] blink_mask
);

    import clock_set_pkg::*;

    localparam int            BW         = $clog2(BLINK_TICKS + 1);
    localparam logic [BW-1:0] C_BLK_LAST = BW'(BLINK_TICKS - 1);

    logic          w_mode_level;
    logic          w_mode_p;
    logic          w_inc_level;
    logic          w_inc_p;
    logic          w_rep_p;
    logic          w_inc_evt;
    logic          w_in_set;
    logic          w_blink_restart;
    logic          w_unused;
    hhmm_t         w_snap;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    hhmm_t         ld_q;
    hhmm_t         ld_d;
    logic          phase_q;
    logic          phase_d;
    logic [BW-1:0] blink_cnt_q;
    logic [BW-1:0] blink_cnt_d;

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_dbn_mode (
        .clk       (clk),
        .rst       (rst),
        .tick_en_i (tick_en),
        .btn_i     (btn_mode),
        .level_o   (w_mode_level),
        .press_o   (w_mode_p)
    );

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_dbn_inc (
        .clk       (clk),
        .rst       (rst),
        .tick_en_i (tick_en),
        .btn_i     (btn_inc),
        .level_o   (w_inc_level),
        .press_o   (w_inc_p)
    );

    assign w_in_set  = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
    assign w_snap    = hhmm_t'({cur_hr1, cur_hr0, cur_min1, cur_min0});
    assign w_inc_evt = w_inc_p | w_rep_p;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX + 1);

    logic [HW-1:0] hold_cnt_q;
    logic          repeating_q;
    logic [HW-1:0] w_hold_target;
    logic          w_hold_run;

    // Hold counting only while a held inc is being applied to a SET state;
    // a mode press or a release restarts the hold delay.
    assign w_hold_run    = w_in_set & w_inc_level & ~w_mode_p;
    assign w_hold_target = repeating_q ? HW'(REPEAT_TICKS - 1) : HW'(HOLD_TICKS - 1);
    assign w_rep_p       = w_hold_run & tick_en & (hold_cnt_q == w_hold_target);

    // Initial hold delay, then periodic repeat while the button stays down
    always_ff @(posedge clk) begin
        if (rst || !w_hold_run) begin
            hold_cnt_q  <= '0;
            repeating_q <= 1'b0;
        end else if (tick_en) begin
            if (w_rep_p) begin
                hold_cnt_q  <= '0;
                repeating_q <= 1'b1;
            end else begin
                hold_cnt_q <= hold_cnt_q + HW'(1);
            end
        end
    end

    assign w_unused = w_mode_level;
`else
    assign w_rep_p  = 1'b0;
    assign w_unused = w_mode_level ^ w_inc_level ^ (HOLD_TICKS > 0) ^ (REPEAT_TICKS > 0);
`endif

    // Set-mode FSM and edit datapath; a mode press always beats an increment
    always_comb begin
        state_d         = state_q;
        ld_d            = ld_q;
        w_blink_restart = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (w_mode_p) begin
                    ld_d            = sanitize(w_snap);
                    state_d         = ST_SET_HR;
                    w_blink_restart = 1'b1;
                end
            end
            ST_SET_HR: begin
                if (w_mode_p) begin
                    state_d         = ST_SET_MIN;
                    w_blink_restart = 1'b1;
                end else if (w_inc_evt) begin
                    ld_d            = hr_inc(ld_q);
                    w_blink_restart = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_p) begin
                    state_d = ST_LOAD;
                end else if (w_inc_evt) begin
                    ld_d            = min_inc(ld_q);
                    w_blink_restart = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Blink phase: restarts visible on entry/increment, toggles every BLINK_TICKS
    always_comb begin
        phase_d     = phase_q;
        blink_cnt_d = blink_cnt_q;
        if (w_blink_restart || !w_in_set) begin
            phase_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (tick_en) begin
            if (blink_cnt_q == C_BLK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // State, edit registers and blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ld_q        <= '0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            phase_q     <= phase_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign run_ena    = (state_q == ST_RUN);
    assign load       = (state_q == ST_LOAD);
    assign set_active = w_in_set;
    assign ld_hr1     = ld_q.hr1;
    assign ld_hr0     = ld_q.hr0;
    assign ld_min1    = ld_q.min1;
    assign ld_min0    = ld_q.min0;
    assign blink_mask = !phase_q                 ? 6'b000000      :
                        (state_q == ST_SET_HR)  ? BLINK_MASK_HR  :
                        (state_q == ST_SET_MIN) ? BLINK_MASK_MIN : 6'b000000;

endmodule

`default_nettype wire
